// File: rtl/fp_vec_engine.sv
// fp_vec_engine: Avalon-MM vector front-end for the floating-point custom-instruction core.
// Software loads up to NUM_PAIRS operand pairs (A[i], B[i]), a COUNT and an opcode,
// then writes CTRL.start. The engine issues one core operation per pair, stores
// each result in R[i], and raises done (or error on a bad start / core timeout).
//
// Ports:
//   clk, reset_n          clock, asynchronous active-low reset
//   slave*                Avalon-MM slave (word addressed, readdatavalid pipelined)
//   irq                   level interrupt = irq_en & (done | error)
//   fp_clk_en, fp_start   core enable / 1-cycle start pulse
//   fp_n, fp_dataa/b      core opcode and operands
//   fp_done, fp_result    core completion pulse and result
//
// Register map (word addresses):
//   0x00 CTRL   W: [0] start, [1] irq_en, [15:8] opcode
//               R: [0] busy, [1] irq_en, [2] done, [3] error, [15:8] opcode
//   0x01 STATUS W1C [2] done, [3] error (reads back done/error in the same bits)
//   0x02 COUNT  [4:0]
//   0x10+i A[i], 0x20+i B[i] (R/W), 0x30+i R[i] (read-only)

// One operand/result slot.
module fp_vec_slot (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        wr_a,
  input  logic        wr_b,
  input  logic        wr_r,
  input  logic [31:0] wdata,
  input  logic [31:0] result,
  output logic [31:0] a,
  output logic [31:0] b,
  output logic [31:0] r
);
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      a <= '0;
      b <= '0;
      r <= '0;
    end else begin
      if (wr_a) a <= wdata;
      if (wr_b) b <= wdata;
      if (wr_r) r <= result;
    end
  end
endmodule

module fp_vec_engine #(
  parameter int NUM_PAIRS = 4,
  parameter int ADDR_W    = 6,
  parameter int TIMEOUT   = 64
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] slaveaddress,
  input  logic              slaveread,
  input  logic              slavewrite,
  input  logic [31:0]       slavewritedata,
  output logic [31:0]       slavereaddata,
  output logic              slavereaddatavalid,
  output logic              slavewaitrequest,
  output logic              irq,
  output logic              fp_clk_en,
  output logic              fp_start,
  output logic [7:0]        fp_n,
  output logic [31:0]       fp_dataa,
  output logic [31:0]       fp_datab,
  input  logic              fp_done,
  input  logic [31:0]       fp_result
);
  localparam int         IW    = (NUM_PAIRS > 1) ? $clog2(NUM_PAIRS) : 1;
  localparam int         DEPTH = 1 << IW;
  localparam int         TW    = $clog2(TIMEOUT + 1);
  localparam logic [4:0] NP5   = 5'(NUM_PAIRS);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;
  state_t state, state_nxt;

  logic [4:0]          idx;
  logic [4:0]          count;
  logic [7:0]          opcode;
  logic                irq_en, done, error;
  logic [TW-1:0]       tmr;
  logic [DEPTH-1:0][31:0] a_q, b_q, r_q;

  // ---- address decode ----
  logic          hi_zero, slot_ok;
  logic [1:0]    region;
  logic [3:0]    sub;
  logic [IW-1:0] slot, cur;
  logic          is_ctrl, is_stat, is_cnt, is_a, is_b, is_r;

  assign hi_zero = ((slaveaddress >> 6) == '0);
  assign region  = slaveaddress[5:4];
  assign sub     = slaveaddress[3:0];
  assign slot_ok = ({1'b0, sub} < NP5);
  assign slot    = sub[IW-1:0];
  assign cur     = idx[IW-1:0];

  assign is_ctrl = hi_zero && (slaveaddress[5:0] == 6'h00);
  assign is_stat = hi_zero && (slaveaddress[5:0] == 6'h01);
  assign is_cnt  = hi_zero && (slaveaddress[5:0] == 6'h02);
  assign is_a    = hi_zero && (region == 2'd1) && slot_ok;
  assign is_b    = hi_zero && (region == 2'd2) && slot_ok;
  assign is_r    = hi_zero && (region == 2'd3) && slot_ok;

  // ---- control decode ----
  logic busy, wr, wr_ok, count_ok, start_req, start_acc, start_bad, busy_err;
  logic res_we, last, tmo, rd_acc;

  assign busy      = (state != S_IDLE);
  assign wr        = slavewrite & ~slaveread;   // a simultaneous read wins
  assign wr_ok     = wr & ~busy;
  assign count_ok  = (count != 5'd0) && (count <= NP5);
  assign start_req = wr & is_ctrl & slavewritedata[0] & ~busy;
  assign start_acc = start_req & count_ok;
  assign start_bad = start_req & ~count_ok;
  assign busy_err  = wr & busy & (is_ctrl | is_cnt | is_a | is_b);
  assign res_we    = (state == S_WAIT) & fp_done;
  assign last      = ((idx + 5'd1) == count);
  assign tmo       = (state == S_WAIT) & ~fp_done & (tmr == TW'(TIMEOUT - 1));

  // Reads of a result slot that has not been produced yet are held off; the
  // stall releases the cycle after idx moves past the slot.
  assign slavewaitrequest = slaveread & busy & is_r & ({1'b0, sub} >= idx);
  assign rd_acc           = slaveread & ~slavewaitrequest;

  assign irq = irq_en & (done | error);

  // ---- slots ----
  for (genvar g = 0; g < DEPTH; g++) begin : g_slot
    fp_vec_slot u_slot (
      .clk    (clk),
      .reset_n(reset_n),
      .wr_a   (wr_ok & is_a & (slot == IW'(g))),
      .wr_b   (wr_ok & is_b & (slot == IW'(g))),
      .wr_r   (res_we & (cur == IW'(g))),
      .wdata  (slavewritedata),
      .result (fp_result),
      .a      (a_q[g]),
      .b      (b_q[g]),
      .r      (r_q[g])
    );
  end

  // ---- FSM ----
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start_acc) state_nxt = S_ISSUE;
      S_ISSUE: state_nxt = S_WAIT;
      S_WAIT: begin
        if (fp_done)  state_nxt = last ? S_IDLE : S_ISSUE;
        else if (tmo) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Operands are held through WAIT so multi-cycle cores see stable inputs.
  always_comb begin
    fp_clk_en = busy;
    fp_start  = (state == S_ISSUE);
    fp_n      = busy ? opcode   : 8'd0;
    fp_dataa  = busy ? a_q[cur] : 32'd0;
    fp_datab  = busy ? b_q[cur] : 32'd0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= S_IDLE;
      idx    <= '0;
      count  <= '0;
      opcode <= '0;
      irq_en <= 1'b0;
      done   <= 1'b0;
      error  <= 1'b0;
      tmr    <= '0;
    end else begin
      state <= state_nxt;

      if (state == S_ISSUE)     tmr <= '0;
      else if (state == S_WAIT) tmr <= tmr + TW'(1);

      if (start_acc)   idx <= '0;
      else if (res_we) idx <= idx + 5'd1;

      if (wr_ok & is_cnt) count <= slavewritedata[4:0];

      if (wr_ok & is_ctrl) begin
        irq_en <= slavewritedata[1];
        opcode <= slavewritedata[15:8];
      end

      // Hardware-raised events take priority over a same-cycle W1C.
      if (start_acc)                            done <= 1'b0;
      else if (res_we & last)                   done <= 1'b1;
      else if (wr & is_stat & slavewritedata[2]) done <= 1'b0;

      if (start_acc)                             error <= 1'b0;
      else if (start_bad | busy_err | tmo)       error <= 1'b1;
      else if (wr & is_stat & slavewritedata[3]) error <= 1'b0;
    end
  end

  // ---- read path ----
  logic [31:0] rd_mux;
  always_comb begin
    rd_mux = '0;
    if (is_ctrl)     rd_mux = {16'd0, opcode, 4'd0, error, done, irq_en, busy};
    else if (is_stat) rd_mux = {28'd0, error, done, 2'd0};
    else if (is_cnt)  rd_mux = {27'd0, count};
    else if (is_a)    rd_mux = a_q[slot];
    else if (is_b)    rd_mux = b_q[slot];
    else if (is_r)    rd_mux = r_q[slot];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      slavereaddata      <= '0;
      slavereaddatavalid <= 1'b0;
    end else begin
      slavereaddatavalid <= rd_acc;
      if (rd_acc) slavereaddata <= rd_mux;
    end
  end
endmodule

// File: tb/tb_fp_vec_engine.sv
module tb_fp_vec_engine;
  localparam int NP = 4;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [5:0]  slaveaddress = '0;
  logic        slaveread = 1'b0, slavewrite = 1'b0;
  logic [31:0] slavewritedata = '0;
  logic [31:0] slavereaddata;
  logic        slavereaddatavalid, slavewaitrequest, irq;
  logic        fp_clk_en, fp_start;
  logic [7:0]  fp_n;
  logic [31:0] fp_dataa, fp_datab;
  logic        fp_done;
  logic [31:0] fp_result;

  always #5 clk = ~clk;

  fp_vec_engine #(.NUM_PAIRS(NP), .ADDR_W(6), .TIMEOUT(64)) dut (
    .clk(clk), .reset_n(reset_n),
    .slaveaddress(slaveaddress), .slaveread(slaveread), .slavewrite(slavewrite),
    .slavewritedata(slavewritedata), .slavereaddata(slavereaddata),
    .slavereaddatavalid(slavereaddatavalid), .slavewaitrequest(slavewaitrequest),
    .irq(irq), .fp_clk_en(fp_clk_en), .fp_start(fp_start), .fp_n(fp_n),
    .fp_dataa(fp_dataa), .fp_datab(fp_datab), .fp_done(fp_done), .fp_result(fp_result)
  );

  int tests = 0, fails = 0;

  // Reference state
  logic [31:0] mA[NP], mB[NP], mR[NP];

  // Stand-in core function: the two add cases from the test plan give true FP sums.
  function automatic logic [31:0] core_fn(input logic [7:0] n, input logic [31:0] a, input logic [31:0] b);
    if (n == 8'hFD && a == 32'h3F800000 && b == 32'h40000000) return 32'h40400000;
    if (n == 8'hFD && a == 32'h40400000 && b == 32'h3F800000) return 32'h40800000;
    return (a + b) ^ {n, n, n, n};
  endfunction

  // Core model: done k cycles after start, or never when hung.
  int          core_lat = 1;
  bit          core_hang = 1'b0;
  int          cdown;
  logic        cact;
  logic [31:0] cres;
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fp_done <= 1'b0; fp_result <= '0; cact <= 1'b0; cdown <= 0; cres <= '0;
    end else begin
      fp_done <= 1'b0;
      if (fp_start && !core_hang) begin
        if (core_lat <= 1) begin
          fp_done <= 1'b1; fp_result <= core_fn(fp_n, fp_dataa, fp_datab);
        end else begin
          cact <= 1'b1; cdown <= core_lat - 1; cres <= core_fn(fp_n, fp_dataa, fp_datab);
        end
      end else if (cact) begin
        if (cdown == 1) begin fp_done <= 1'b1; fp_result <= cres; cact <= 1'b0; end
        else cdown <= cdown - 1;
      end
    end
  end

  // All bus tasks start and end on a falling edge.
  task automatic bus_write(input logic [5:0] addr, input logic [31:0] data);
    slaveaddress = addr; slavewritedata = data; slavewrite = 1'b1;
    @(negedge clk); slavewrite = 1'b0;
  endtask

  task automatic bus_read(input logic [5:0] addr, output logic [31:0] data, output int stalls);
    int n = 0;
    slaveaddress = addr; slaveread = 1'b1; #1;
    while (slavewaitrequest && n < 200) begin @(negedge clk); #1; n++; end
    stalls = n;
    if (n >= 200) begin tests++; fails++; $display("FAIL rd_stall_bound addr=%h", addr); end
    @(negedge clk); slaveread = 1'b0;
    tests++;
    if (slavereaddatavalid !== 1'b1) begin fails++; $display("FAIL rd_valid addr=%h got %b want 1", addr, slavereaddatavalid); end
    data = slavereaddata;
  endtask

  task automatic load_pairs(input int n);
    for (int i = 0; i < n; i++) begin
      mA[i] = $urandom; mB[i] = $urandom;
      bus_write(6'h10 + 6'(i), mA[i]);
      bus_write(6'h20 + 6'(i), mB[i]);
    end
  endtask

  // Observes a run from the current falling edge until cnt dones are seen.
  // Reports start/done counts, starts with wrong operands, missing back-to-back
  // starts after a non-final done, and irq one cycle after the final done.
  task automatic watch_run(input int cnt, input int ei0, input logic [7:0] op,
                           output int ns, output int nd, output int nbad, output int ngap,
                           output logic irq_after);
    int budget = 0; int ei = ei0; bit exp_start = 0;
    ns = 0; nd = 0; nbad = 0; ngap = 0;
    while (nd < cnt && budget < 2000) begin
      if (exp_start && fp_start !== 1'b1) ngap++;
      exp_start = 0;
      if (fp_start === 1'b1) begin
        ns++;
        if (ei >= NP || fp_n !== op || fp_dataa !== mA[ei] || fp_datab !== mB[ei]) nbad++;
        ei++;
      end
      if (fp_done === 1'b1) begin nd++; if (nd < cnt) exp_start = 1; end
      @(negedge clk); budget++;
    end
    irq_after = irq;
  endtask

  task automatic test_reset;
    logic [31:0] d; int s;
    repeat (2) @(negedge clk);
    tests++;
    if ({slavereaddata, slavereaddatavalid, slavewaitrequest, irq, fp_clk_en, fp_start, fp_n, fp_dataa, fp_datab} !== '0) begin
      fails++; $display("FAIL reset_outputs: some output nonzero during reset");
    end
    reset_n = 1'b1;
    for (int i = 0; i < NP; i++) begin mA[i] = '0; mB[i] = '0; mR[i] = '0; end
    bus_read(6'h00, d, s); tests++;
    if (d !== 32'h0) begin fails++; $display("FAIL reset_ctrl got %h want 0", d); end
    bus_read(6'h02, d, s); tests++;
    if (d !== 32'h0) begin fails++; $display("FAIL reset_count got %h want 0", d); end
    bus_read(6'h10, d, s); tests++;
    if (d !== 32'h0) begin fails++; $display("FAIL reset_a0 got %h want 0", d); end
    bus_read(6'h30, d, s); tests++;
    if (d !== 32'h0) begin fails++; $display("FAIL reset_r0 got %h want 0", d); end
  endtask

  task automatic test_add;
    logic [31:0] d; int s, ns, nd, nb, ng; logic ia;
    core_lat = 2;
    mA[0] = 32'h3F800000; mB[0] = 32'h40000000; mA[1] = 32'h40400000; mB[1] = 32'h3F800000;
    bus_write(6'h10, mA[0]); bus_write(6'h20, mB[0]);
    bus_write(6'h11, mA[1]); bus_write(6'h21, mB[1]);
    bus_write(6'h02, 32'd2);
    bus_write(6'h00, 32'h0000FD01);
    tests++;
    if (fp_start !== 1'b1) begin fails++; $display("FAIL add_start_latency got %b want 1", fp_start); end
    watch_run(2, 0, 8'hFD, ns, nd, nb, ng, ia);
    tests++;
    if (ns !== 2 || nd !== 2 || nb !== 0 || ng !== 0) begin
      fails++; $display("FAIL add_run starts=%0d dones=%0d bad=%0d gaps=%0d want 2 2 0 0", ns, nd, nb, ng);
    end
    mR[0] = 32'h40400000; mR[1] = 32'h40800000;
    bus_read(6'h30, d, s); tests++;
    if (d !== 32'h40400000) begin fails++; $display("FAIL add_r0 got %h want 40400000", d); end
    bus_read(6'h31, d, s); tests++;
    if (d !== 32'h40800000) begin fails++; $display("FAIL add_r1 got %h want 40800000", d); end
    bus_read(6'h00, d, s); tests++;
    if (d !== 32'h0000FD04) begin fails++; $display("FAIL add_ctrl got %h want 0000fd04", d); end
  endtask

  task automatic test_random_runs;
    logic [31:0] d; int s, ns, nd, nb, ng, cnt; logic ia; logic [7:0] op;
    for (int it = 0; it < 6; it++) begin
      cnt = $urandom_range(1, NP); op = 8'($urandom); core_lat = $urandom_range(1, 4);
      load_pairs(NP);
      bus_write(6'h02, 32'(cnt));
      bus_write(6'h00, {16'd0, op, 8'h03});
      watch_run(cnt, 0, op, ns, nd, nb, ng, ia);
      tests++;
      if (ns !== cnt || nd !== cnt || nb !== 0 || ng !== 0) begin
        fails++; $display("FAIL rand_run%0d starts=%0d dones=%0d bad=%0d gaps=%0d want %0d %0d 0 0", it, ns, nd, nb, ng, cnt, cnt);
      end
      tests++;
      if (ia !== 1'b1) begin fails++; $display("FAIL rand_irq_timing%0d got %b want 1", it, ia); end
      for (int i = 0; i < cnt; i++) mR[i] = core_fn(op, mA[i], mB[i]);
      for (int i = 0; i < NP; i++) begin
        bus_read(6'h30 + 6'(i), d, s); tests++;
        if (d !== mR[i]) begin fails++; $display("FAIL rand_r%0d it%0d got %h want %h", i, it, d, mR[i]); end
      end
      bus_read(6'h00, d, s); tests++;
      if (d !== {16'd0, op, 8'h06}) begin fails++; $display("FAIL rand_ctrl it%0d got %h want %h", it, d, {16'd0, op, 8'h06}); end
      bus_write(6'h01, 32'h4); tests++;
      if (irq !== 1'b0) begin fails++; $display("FAIL rand_w1c_irq it%0d got %b want 0", it, irq); end
    end
  endtask

  task automatic test_stalled_read;
    logic [31:0] d; int s; logic [7:0] op;
    op = 8'($urandom); core_lat = 5;
    load_pairs(1);
    bus_write(6'h02, 32'd1);
    bus_write(6'h00, {16'd0, op, 8'h01});
    mR[0] = core_fn(op, mA[0], mB[0]);
    bus_read(6'h30, d, s);
    tests++;
    if (s !== 6) begin fails++; $display("FAIL stall_cycles got %0d want 6", s); end
    tests++;
    if (d !== mR[0]) begin fails++; $display("FAIL stall_data got %h want %h", d, mR[0]); end
    @(negedge clk); tests++;
    if (slavereaddatavalid !== 1'b0) begin fails++; $display("FAIL stall_valid_one_cycle got %b want 0", slavereaddatavalid); end
  endtask

  task automatic test_bad_start;
    logic [31:0] d; int s, nst; int cv[2];
    cv[0] = 0; cv[1] = NP + 1;
    for (int k = 0; k < 2; k++) begin
      bus_write(6'h02, 32'(cv[k]));
      bus_write(6'h00, 32'h00000001);
      nst = 0;
      repeat (4) begin if (fp_start === 1'b1) nst++; @(negedge clk); end
      tests++;
      if (nst !== 0) begin fails++; $display("FAIL bad_start_nostart count=%0d got %0d starts want 0", cv[k], nst); end
      bus_read(6'h00, d, s); tests++;
      if ((d & 32'h9) !== 32'h8) begin fails++; $display("FAIL bad_start_err count=%0d got %h want error=1 busy=0", cv[k], d); end
      bus_write(6'h01, 32'h8);
      bus_read(6'h00, d, s); tests++;
      if ((d & 32'h8) !== 32'h0) begin fails++; $display("FAIL bad_start_w1c count=%0d got %h want error=0", cv[k], d); end
    end
  endtask

  task automatic test_timeout;
    logic [31:0] d; int s;
    core_hang = 1'b1;
    bus_write(6'h02, 32'd1);
    bus_write(6'h00, 32'h00004203);
    tests++;
    if (fp_start !== 1'b1) begin fails++; $display("FAIL tmo_start got %b want 1", fp_start); end
    repeat (64) @(negedge clk);
    tests++;
    if (irq !== 1'b0) begin fails++; $display("FAIL tmo_early got irq=%b want 0 at S+64", irq); end
    @(negedge clk); tests++;
    if (irq !== 1'b1) begin fails++; $display("FAIL tmo_at_65 got irq=%b want 1", irq); end
    bus_read(6'h00, d, s); tests++;
    if ((d & 32'hD) !== 32'h8) begin fails++; $display("FAIL tmo_status got %h want error=1 done=0 busy=0", d); end
    bus_read(6'h30, d, s); tests++;
    if (d !== mR[0]) begin fails++; $display("FAIL tmo_r0_kept got %h want %h", d, mR[0]); end
    core_hang = 1'b0;
    bus_write(6'h01, 32'hC); tests++;
    if (irq !== 1'b0) begin fails++; $display("FAIL tmo_clear got irq=%b want 0", irq); end
  endtask

  task automatic test_busy_protect;
    logic [31:0] d; int s, ns, nd, nb, ng; logic ia; logic [7:0] op;
    op = 8'($urandom); core_lat = 8;
    load_pairs(2);
    bus_write(6'h02, 32'd2);
    bus_write(6'h00, {16'd0, op, 8'h01});
    repeat (2) @(negedge clk);
    bus_write(6'h10, ~mA[0]);
    watch_run(2, 1, op, ns, nd, nb, ng, ia);
    tests++;
    if (ns !== 1 || nd !== 2 || nb !== 0 || ng !== 0) begin
      fails++; $display("FAIL busy_run starts=%0d dones=%0d bad=%0d gaps=%0d want 1 2 0 0", ns, nd, nb, ng);
    end
    for (int i = 0; i < 2; i++) mR[i] = core_fn(op, mA[i], mB[i]);
    bus_read(6'h10, d, s); tests++;
    if (d !== mA[0]) begin fails++; $display("FAIL busy_a0_kept got %h want %h", d, mA[0]); end
    bus_read(6'h00, d, s); tests++;
    if ((d & 32'hD) !== 32'hC) begin fails++; $display("FAIL busy_status got %h want error=1 done=1 busy=0", d); end
    for (int i = 0; i < 2; i++) begin
      bus_read(6'h30 + 6'(i), d, s); tests++;
      if (d !== mR[i]) begin fails++; $display("FAIL busy_r%0d got %h want %h", i, d, mR[i]); end
    end
    bus_write(6'h01, 32'hC);
  endtask

  task automatic test_rw_collision;
    logic [31:0] d; int s;
    slaveaddress = 6'h10; slavewritedata = ~mA[0]; slaveread = 1'b1; slavewrite = 1'b1;
    @(negedge clk); slaveread = 1'b0; slavewrite = 1'b0;
    tests++;
    if (slavereaddatavalid !== 1'b1 || slavereaddata !== mA[0]) begin
      fails++; $display("FAIL rw_read valid=%b data=%h want 1 %h", slavereaddatavalid, slavereaddata, mA[0]);
    end
    bus_read(6'h10, d, s); tests++;
    if (d !== mA[0]) begin fails++; $display("FAIL rw_write_dropped got %h want %h", d, mA[0]); end
  endtask

  task automatic test_reset_midrun;
    logic [31:0] d; int s, ns, nd, nb, ng; logic ia; logic [7:0] op;
    core_lat = 10;
    load_pairs(1);
    bus_write(6'h02, 32'd1);
    bus_write(6'h00, 32'h00007703);
    repeat (3) @(negedge clk);
    reset_n = 1'b0; #1;
    tests++;
    if ({slavereaddata, slavereaddatavalid, slavewaitrequest, irq, fp_clk_en, fp_start, fp_n, fp_dataa, fp_datab} !== '0) begin
      fails++; $display("FAIL rst_mid_outputs: some output nonzero after async reset");
    end
    @(negedge clk); @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < NP; i++) begin mA[i] = '0; mB[i] = '0; mR[i] = '0; end
    repeat (15) @(negedge clk);
    tests++;
    if (irq !== 1'b0) begin fails++; $display("FAIL rst_mid_no_irq got %b want 0", irq); end
    bus_read(6'h00, d, s); tests++;
    if (d !== 32'h0) begin fails++; $display("FAIL rst_mid_ctrl got %h want 0", d); end
    bus_read(6'h10, d, s); tests++;
    if (d !== 32'h0) begin fails++; $display("FAIL rst_mid_a0 got %h want 0", d); end
    bus_read(6'h30, d, s); tests++;
    if (d !== 32'h0) begin fails++; $display("FAIL rst_mid_r0 got %h want 0", d); end
    op = 8'($urandom); core_lat = 3;
    load_pairs(1);
    bus_write(6'h02, 32'd1);
    bus_write(6'h00, {16'd0, op, 8'h01});
    watch_run(1, 0, op, ns, nd, nb, ng, ia);
    tests++;
    if (ns !== 1 || nd !== 1 || nb !== 0) begin fails++; $display("FAIL rst_mid_rerun starts=%0d dones=%0d bad=%0d want 1 1 0", ns, nd, nb); end
    mR[0] = core_fn(op, mA[0], mB[0]);
    bus_read(6'h30, d, s); tests++;
    if (d !== mR[0]) begin fails++; $display("FAIL rst_mid_rerun_r0 got %h want %h", d, mR[0]); end
  endtask

  initial begin
    test_reset;
    test_add;
    test_random_runs;
    test_stalled_read;
    test_bad_start;
    test_timeout;
    test_busy_protect;
    test_rw_collision;
    test_reset_midrun;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
